// File: rtl/square_root_arbiter_pkg.sv
// Shared definitions for the square-root arbiter: state encoding and the
// fixed-point widths of the operand (Q32.32) and the result (Q16.16).
package square_root_arbiter_pkg;

  localparam int LONG_WIDTH   = 64;  // Q32.32 operand
  localparam int RESULT_WIDTH = 32;  // Q16.16 result

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : square_root_arbiter_pkg

// File: rtl/rr_priority_picker.sv
// Round-robin picker: returns a one-hot grant for the first set request
// found when scanning upward from ptr_i, wrapping at NUM_REQ.
module rr_priority_picker
  import square_root_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int idx;

  // Scan from the farthest offset down to the pointer so the closest
  // requester at or after the pointer is the last (winning) assignment.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule : rr_priority_picker

// File: rtl/square_root_arbiter.sv
// Shares one square-root unit between NUM_REQ requesters. A requester is
// picked round-robin, its operand is latched and handed to the unit, the
// result is returned with a one-cycle oDone pulse, and a wait counter
// guards against a unit that never answers.
module square_root_arbiter
  import square_root_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = LONG_WIDTH,
  parameter int RESULT_WIDTH   = square_root_arbiter_pkg::RESULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               iRequest,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOperand,
  output logic [NUM_REQ-1:0]               oGrant,
  output logic [NUM_REQ-1:0]               oDone,
  output logic [RESULT_WIDTH-1:0]          oResult,
  output logic [OPERAND_WIDTH-1:0]         oSqrtOperand,
  output logic                             oSqrtInputReady,
  input  logic                             iSqrtOutputReady,
  input  logic [RESULT_WIDTH-1:0]          iSqrtResult,
  output logic                             oBusy,
  output logic                             oTimeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter times out on the cycle it would step to TIMEOUT_CYCLES,
  // so exactly TIMEOUT_CYCLES BUSY cycles elapse before oTimeout rises.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]               rst_sync_q;
  logic                     rst_n;
  state_e                   state_q;
  logic [PTR_W-1:0]         ptr_q;
  logic [CNT_W-1:0]         wait_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [NUM_REQ-1:0]       done_q;
  logic [RESULT_WIDTH-1:0]  result_q;
  logic [OPERAND_WIDTH-1:0] operand_q;
  logic                     in_ready_q;
  logic                     timeout_q;

  logic [NUM_REQ-1:0]       pick;
  logic [PTR_W-1:0]         pick_idx;
  logic [PTR_W-1:0]         gnt_idx;
  logic [PTR_W-1:0]         ptr_d;

  // Reset asserts asynchronously but releases only after two clock edges.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (iRequest),
    .ptr_i   (ptr_q),
    .grant_o (pick)
  );

  // Binary index of the freshly picked and of the current owner, plus the
  // pointer value that places the current owner last in line.
  always_comb begin
    pick_idx = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i])    pick_idx = PTR_W'(i);
      if (grant_q[i]) gnt_idx  = PTR_W'(i);
    end
    ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      wait_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      result_q   <= '0;
      operand_q  <= '0;
      in_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|iRequest) begin
            grant_q    <= pick;
            operand_q  <= iOperand[int'(pick_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            in_ready_q <= 1'b1;
            wait_q     <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (iSqrtOutputReady) begin
            // A withdrawn requester still updates oResult but gets no pulse.
            result_q   <= iSqrtResult;
            done_q     <= grant_q & iRequest;
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end else if (wait_q == WAIT_LAST) begin
            timeout_q  <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!iSqrtOutputReady) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oGrant          = grant_q;
  assign oDone           = done_q;
  assign oResult         = result_q;
  assign oSqrtOperand    = operand_q;
  assign oSqrtInputReady = in_ready_q;
  assign oBusy           = (state_q != IDLE);
  assign oTimeout        = timeout_q;

endmodule : square_root_arbiter

// File: tb/tb_square_root_arbiter.sv
// Directed bench for square_root_arbiter. The bench plays the square-root
// unit with a fixed-latency stub whose answers are a hand-computed table.
module tb_square_root_arbiter;

  localparam logic [63:0] OP_1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] OP_2 = 64'h0000_0002_0000_0000;
  localparam logic [63:0] OP_4 = 64'h0000_0004_0000_0000;
  localparam logic [63:0] OP_9 = 64'h0000_0009_0000_0000;
  localparam logic [31:0] RS_1 = 32'h0001_0000;
  localparam logic [31:0] RS_2 = 32'h0001_6A09;
  localparam logic [31:0] RS_4 = 32'h0002_0000;
  localparam logic [31:0] RS_9 = 32'h0003_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   iRequest = '0;
  logic [255:0] iOperand = '0;
  logic [3:0]   oGrant, oDone;
  logic [31:0]  oResult;
  logic [63:0]  oSqrtOperand;
  logic         oSqrtInputReady;
  logic         sqrt_ready = 1'b0;
  logic [31:0]  sqrt_result = '0;
  logic         oBusy, oTimeout;

  int checks = 0;
  int failures = 0;
  int onehot_viol = 0;
  int done_cnt[4] = '{0, 0, 0, 0};
  int stub_cnt = 0;
  int stub_lat = 3;
  bit stub_en = 1'b1;
  int snap;

  square_root_arbiter dut (
    .Clock            (clk),
    .Reset            (rst_n),
    .iRequest         (iRequest),
    .iOperand         (iOperand),
    .oGrant           (oGrant),
    .oDone            (oDone),
    .oResult          (oResult),
    .oSqrtOperand     (oSqrtOperand),
    .oSqrtInputReady  (oSqrtInputReady),
    .iSqrtOutputReady (sqrt_ready),
    .iSqrtResult      (sqrt_result),
    .oBusy            (oBusy),
    .oTimeout         (oTimeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sqrt_lut(input logic [63:0] op);
    case (op)
      OP_1:    return RS_1;
      OP_2:    return RS_2;
      OP_4:    return RS_4;
      OP_9:    return RS_9;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Square-root unit stub: answers stub_lat cycles after start, holds the
  // answer until the start level drops.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      sqrt_ready = 1'b0;
      stub_cnt   = 0;
    end else if (oSqrtInputReady) begin
      if (!sqrt_ready && stub_en) begin
        stub_cnt++;
        if (stub_cnt >= stub_lat) begin
          sqrt_ready  = 1'b1;
          sqrt_result = sqrt_lut(oSqrtOperand);
        end
      end
    end else begin
      sqrt_ready = 1'b0;
      stub_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    if ($countones(oGrant) > 1 || $countones(oDone) > 1) onehot_viol++;
    for (int i = 0; i < 4; i++) if (oDone[i]) done_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [63:0] v);
    iOperand[k*64 +: 64] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},    64'(oGrant), 64'h0);
    check({tag, "_done"},     64'(oDone), 64'h0);
    check({tag, "_result"},   64'(oResult), 64'h0);
    check({tag, "_operand"},  oSqrtOperand, 64'h0);
    check({tag, "_in_ready"}, 64'(oSqrtInputReady), 64'h0);
    check({tag, "_busy"},     64'(oBusy), 64'h0);
    check({tag, "_timeout"},  64'(oTimeout), 64'h0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    iRequest = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Waits for the current owner to be released, then for the next grant.
  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (oGrant != 0 && n < 60) begin @(negedge clk); n++; end
    while (oGrant == 0 && n < 60) begin @(negedge clk); n++; end
    check({tag, "_grant"}, 64'(oGrant), 64'(exp));
  endtask

  task automatic wait_done(input string tag, input int idx, input logic [31:0] exp_res,
                           input bit drop);
    int n = 0;
    while (oDone == 0 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_done"},   64'(oDone), 64'(1) << idx);
    check({tag, "_result"}, 64'(oResult), 64'(exp_res));
    if (drop) iRequest[idx] = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"},  64'(oDone), 64'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oBusy && n < 60) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 64'(oBusy), 64'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 64'(oBusy), 64'h0);

    // Single request from requester 2, operand 4.0, one-cycle grant latency
    set_op(2, OP_4);
    iRequest = 4'b0100;
    @(negedge clk);
    check("t1_grant",    64'(oGrant), 64'h4);
    check("t1_in_ready", 64'(oSqrtInputReady), 64'h1);
    check("t1_operand",  oSqrtOperand, OP_4);
    check("t1_busy",     64'(oBusy), 64'h1);
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("t1_operand_held", oSqrtOperand, OP_4);
    wait_done("t1", 2, RS_4, 1'b1);
    wait_idle("t1");

    // Operand 2.0 from requester 0 (pointer sits at 3, wraps to 0)
    set_op(0, OP_2);
    iRequest = 4'b0001;
    wait_grant("t2", 4'b0001);
    wait_done("t2", 0, RS_2, 1'b1);
    wait_idle("t2");

    // All four requests held from reset: grant order 0,1,2,3,0
    do_reset();
    set_op(0, OP_1); set_op(1, OP_4); set_op(2, OP_9); set_op(3, OP_2);
    iRequest = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("rr%0d", k), 4'(1 << (k % 4)));
      case (k % 4)
        0:       wait_done($sformatf("rr%0d", k), 0, RS_1, 1'b0);
        1:       wait_done($sformatf("rr%0d", k), 1, RS_4, 1'b0);
        2:       wait_done($sformatf("rr%0d", k), 2, RS_9, 1'b0);
        default: wait_done($sformatf("rr%0d", k), 3, RS_2, 1'b0);
      endcase
    end
    iRequest = '0;
    wait_idle("rr");
    check("onehot", 64'(onehot_viol), 64'h0);

    // Requester 1 withdraws mid-BUSY: no pulse, result still updates
    stub_lat = 8;
    set_op(1, OP_9);
    snap = done_cnt[1];
    iRequest = 4'b0010;
    wait_grant("wd", 4'b0010);
    repeat (2) @(negedge clk);
    iRequest = 4'b0000;
    wait_idle("wd");
    check("wd_no_done", 64'(done_cnt[1] - snap), 64'h0);
    check("wd_result",  64'(oResult), 64'(RS_9));
    // Pointer now at 2: of requesters 1 and 3, requester 3 wins
    stub_lat = 3;
    iRequest = 4'b1010;
    wait_grant("wd_ptr", 4'b1000);
    wait_done("wd_ptr", 3, RS_2, 1'b1);
    wait_grant("wd_next", 4'b0010);
    wait_done("wd_next", 1, RS_9, 1'b1);
    wait_idle("wd_next");

    // Unit never answers: timeout after 255 BUSY cycles, next requester served
    stub_en = 1'b0;
    set_op(2, OP_4);
    snap = done_cnt[2];
    iRequest = 4'b1100;
    wait_grant("to", 4'b0100);
    repeat (254) @(negedge clk);
    check("to_not_yet",      64'(oTimeout), 64'h0);
    check("to_ready_before", 64'(oSqrtInputReady), 64'h1);
    @(negedge clk);
    check("to_flag",         64'(oTimeout), 64'h1);
    check("to_ready_after",  64'(oSqrtInputReady), 64'h0);
    check("to_result_kept",  64'(oResult), 64'(RS_9));
    iRequest[2] = 1'b0;
    stub_en = 1'b1;
    wait_grant("to_next", 4'b1000);
    wait_done("to_next", 3, RS_2, 1'b1);
    check("to_no_done",  64'(done_cnt[2] - snap), 64'h0);
    check("to_sticky",   64'(oTimeout), 64'h1);
    wait_idle("to");

    // Reset 10 cycles into BUSY clears everything at once
    stub_lat = 20;
    set_op(0, OP_1);
    iRequest = 4'b0001;
    wait_grant("mr", 4'b0001);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mr");
    iRequest = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    stub_lat = 3;
    iRequest = 4'b0001;
    wait_grant("mr_fresh", 4'b0001);
    wait_done("mr_fresh", 0, RS_1, 1'b1);
    wait_idle("mr_fresh");
    check("mr_timeout_clear", 64'(oTimeout), 64'h0);
    check("onehot_final", 64'(onehot_viol), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_square_root_arbiter

// File: doc/square_root_arbiter.md
SQUARE_ROOT_ARBITER -- requirements
Module: square_root_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one square-root unit.
REQ-002 The block SHALL have parameter OPERAND_WIDTH, default 64, for Q32.32 operands.
REQ-003 The block SHALL have parameter RESULT_WIDTH, default 32, for Q16.16 results.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum wait for a result.
REQ-005 The block SHALL have one clock and asynchronous active-low reset: Clock in 1, sole clock, all state on rising edge; Reset in 1, asynchronous, active-low.
REQ-006 The block SHALL have the following requester ports:
- iRequest in NUM_REQ: per-requester request level.
- iOperand in NUM_REQ*OPERAND_WIDTH: packed operands, requester i at bits [i*64+63:i*64].
- oGrant out NUM_REQ: one-hot, owner of the unit.
- oDone out NUM_REQ: one-cycle completion pulse.
- oResult out RESULT_WIDTH: last delivered result.
REQ-007 The block SHALL have the following square-root unit ports:
- oSqrtOperand out OPERAND_WIDTH: operand to the unit.
- oSqrtInputReady out 1: unit start level.
- iSqrtOutputReady in 1: unit result-valid level.
- iSqrtResult in RESULT_WIDTH: unit result.
REQ-008 The block SHALL have the following status ports:
- oBusy out 1: the state is not IDLE.
- oTimeout out 1: sticky timeout flag.

Function
REQ-009 The block SHALL implement states IDLE, BUSY and DRAIN.
REQ-010 In IDLE, when any iRequest bit is set, the block SHALL select one requester by round-robin starting at the priority pointer, and on the same edge SHALL register oGrant, latch oSqrtOperand from that requester's operand slice, assert oSqrtInputReady and enter BUSY.
REQ-011 oSqrtOperand SHALL stay constant from grant until DRAIN exits, regardless of changes on iOperand.
REQ-012 In BUSY, while iSqrtOutputReady=0, a wait counter SHALL increment each cycle.
REQ-013 When iSqrtOutputReady=1 in BUSY, the next edge SHALL:
- capture iSqrtResult into oResult;
- pulse oDone[granted] high for exactly one cycle, only if iRequest[granted] is still 1;
- deassert oSqrtInputReady;
- enter DRAIN.
REQ-014 If the wait counter reaches TIMEOUT_CYCLES in BUSY, the block SHALL set oTimeout, deassert oSqrtInputReady, suppress oDone, leave oResult unchanged and enter DRAIN.
REQ-015 oTimeout SHALL remain set until reset.
REQ-016 In DRAIN, the block SHALL wait until iSqrtOutputReady=0; on that edge it SHALL clear oGrant, advance the pointer to (granted+1) mod NUM_REQ and enter IDLE.
REQ-017 A requester withdrawing iRequest during BUSY SHALL NOT abort the operation; its result is discarded (no oDone) but oResult still updates.
REQ-018 A requester SHALL hold iRequest until oDone; iRequest still high in the cycle after oDone SHALL be treated as a new request, arbitrated behind the other requesters.
REQ-019 At most one oGrant bit and at most one oDone bit SHALL ever be set.
REQ-020 Minimum request-to-oSqrtInputReady latency SHALL be 1 cycle; oDone SHALL follow iSqrtOutputReady by 1 cycle.
REQ-021 With NUM_REQ=1, the block SHALL degenerate to a pass-through sequencer with an identical handshake.

Reset
REQ-022 Asserting Reset low, at any time including mid-BUSY, SHALL immediately force state IDLE, priority pointer 0, wait counter 0, and oGrant, oDone, oResult, oSqrtOperand, oSqrtInputReady, oBusy and oTimeout all 0.
REQ-023 Reset deassertion SHALL be synchronised to Clock before use.

Structure
REQ-024 State encodings and the width constants for 64-bit long and 32-bit result SHALL reside in the shared definitions package.
REQ-025 The round-robin selection SHALL be a combinational sub-module rr_priority_picker (request vector, pointer -> one-hot grant).

Verification
REQ-026 Single request, requester 2, operand 0x0000_0004_0000_0000 (4.0) -> oGrant=0100 next cycle, oResult=0x0002_0000, oDone[2] high exactly one cycle.
REQ-027 Operand 0x0000_0002_0000_0000 (2.0) -> oResult=0x0001_6A09.
REQ-028 All four iRequest held high from reset -> grant order 0,1,2,3,0, one oDone per grant, never two grant bits set.
REQ-029 Stub unit that never raises iSqrtOutputReady -> oTimeout=1 after 255 BUSY cycles, no oDone, return to IDLE, next requester served.
REQ-030 Reset asserted 10 cycles into BUSY -> all outputs 0 immediately; after release, a fresh request completes normally.
REQ-031 Requester 1 drops iRequest mid-BUSY -> no oDone[1], oResult updated, pointer advances to 2.
